// File: rtl/core_pkg.sv
// Shared encodings for the commit stage: CSR ops, interrupt causes, FSM states
// and the layout of the writeback stage register payload.
package core_pkg;

   localparam logic [1:0] CSR_RW = 2'd0;
   localparam logic [1:0] CSR_RS = 2'd1;
   localparam logic [1:0] CSR_RC = 2'd2;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   typedef enum logic {
      RUN   = 1'b0,
      SLEEP = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic        rd_write;
      logic [4:0]  rd_address;
      logic [31:0] rd_data;
      logic        csr_write;
      logic [1:0]  csr_op;
      logic [11:0] csr_address;
      logic [31:0] csr_operand;
      logic [31:0] csr_old;
      logic        exception;
      logic [3:0]  exception_cause;
      logic        mret;
      logic        wfi;
   } wb_stage_t;

endpackage

// File: rtl/csr_alu.sv
// CSR read-modify-write data path: produces the value written back for csrrw/rs/rc.
module csr_alu
   import core_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic [31:0] i_old,
   input  logic [31:0] i_operand,
   output logic [31:0] o_data
);

   always_comb begin
      case (i_op)
         CSR_RS:  o_data = i_old | i_operand;
         CSR_RC:  o_data = i_old & ~i_operand;
         // CSR_RW and the reserved encoding both write the operand unchanged
         default: o_data = i_operand;
      endcase
   end

endmodule

// File: rtl/writeback_trap.sv
// Writeback/commit stage: registers the memory-stage instruction and commits it,
// arbitrating interrupts, exceptions, mret and WFI sleep; drives the CSR write/trap port.
module writeback_trap
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [31:0] pc_in,
   input  logic        rd_write_in,
   input  logic [4:0]  rd_address_in,
   input  logic [31:0] rd_data_in,
   input  logic        csr_write_in,
   input  logic [1:0]  csr_op_in,
   input  logic [11:0] csr_address_in,
   input  logic [31:0] csr_operand_in,
   input  logic [31:0] csr_old_in,
   input  logic        exception_in,
   input  logic [3:0]  exception_cause_in,
   input  logic        mret_in,
   input  logic        wfi_in,
   input  logic        eip,
   input  logic        tip,
   input  logic        sip,
   output logic        reg_write_enable,
   output logic [4:0]  reg_write_address,
   output logic [31:0] reg_write_data,
   output logic        write_enable,
   output logic [11:0] write_address,
   output logic [31:0] write_data,
   output logic        retired,
   output logic        traped,
   output logic        mret,
   output logic [31:0] ecp,
   output logic [3:0]  trap_cause,
   output logic        interupt,
   output logic        fetch_trap,
   output logic        fetch_mret,
   output logic        flush,
   output logic        stall
);

   logic        r_valid;
   logic [31:0] r_pc;
   wb_state_e   r_state;
   wb_stage_t   r_stage;

   logic        w_irq_any;
   logic        w_take_irq;
   logic        w_load;
   logic        w_enter_sleep;
   logic [3:0]  w_irq_cause;
   logic [31:0] w_csr_data;

   assign w_irq_any   = eip | tip | sip;
   assign w_take_irq  = r_valid & w_irq_any;
   assign w_irq_cause = eip ? CAUSE_MEI : (sip ? CAUSE_MSI : CAUSE_MTI);
   // While asleep the held instruction must survive the wake cycle; only an empty stage refills.
   assign w_load      = (r_state == RUN) || !r_valid;

   csr_alu u_csr_alu (
      .i_op      (r_stage.csr_op),
      .i_old     (r_stage.csr_old),
      .i_operand (r_stage.csr_operand),
      .o_data    (w_csr_data)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path through the priority chain infers a latch.
      reg_write_enable  = 1'b0;
      reg_write_address = '0;
      reg_write_data    = '0;
      write_enable      = 1'b0;
      write_address     = '0;
      write_data        = '0;
      retired           = 1'b0;
      traped            = 1'b0;
      mret              = 1'b0;
      ecp               = '0;
      trap_cause        = '0;
      interupt          = 1'b0;
      fetch_trap        = 1'b0;
      fetch_mret        = 1'b0;
      flush             = 1'b0;
      stall             = 1'b0;
      w_enter_sleep     = 1'b0;

      if (r_state == SLEEP) begin
         stall = !w_take_irq;
      end else if (r_valid) begin
         if (w_irq_any || r_stage.exception) begin
            traped     = 1'b1;
            interupt   = w_irq_any;
            trap_cause = w_irq_any ? w_irq_cause : r_stage.exception_cause;
            ecp        = r_pc;
            fetch_trap = 1'b1;
            flush      = 1'b1;
         end else if (r_stage.mret) begin
            mret       = 1'b1;
            retired    = 1'b1;
            fetch_mret = 1'b1;
            flush      = 1'b1;
         end else begin
            retired           = 1'b1;
            reg_write_enable  = r_stage.rd_write && (r_stage.rd_address != 5'd0);
            reg_write_address = r_stage.rd_address;
            reg_write_data    = r_stage.rd_data;
            write_enable      = r_stage.csr_write;
            write_address     = r_stage.csr_address;
            write_data        = w_csr_data;
            w_enter_sleep     = r_stage.wfi;
         end
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= RESET_PC;
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:     if (w_enter_sleep) r_state <= SLEEP;
            SLEEP:   if (w_take_irq) r_state <= RUN;
            default: r_state <= RUN;
         endcase
         if (w_load) begin
            r_valid <= valid_in && !flush;
            r_pc    <= pc_in;
         end
      end
   end

   // NOTE: the payload is only consumed while r_valid=1, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_stage <= '{
            rd_write:        rd_write_in,
            rd_address:      rd_address_in,
            rd_data:         rd_data_in,
            csr_write:       csr_write_in,
            csr_op:          csr_op_in,
            csr_address:     csr_address_in,
            csr_operand:     csr_operand_in,
            csr_old:         csr_old_in,
            exception:       exception_in,
            exception_cause: exception_cause_in,
            mret:            mret_in,
            wfi:             wfi_in
         };
      end
   end

endmodule

// File: tb/tb_writeback_trap.sv
// Scoreboard bench for writeback_trap: each driven instruction pushes the outputs
// expected in its commit cycle (plus the interrupt lines for that cycle).
module tb_writeback_trap;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rd_write;
      logic [4:0]  rd_address;
      logic [31:0] rd_data;
      logic        csr_write;
      logic [1:0]  csr_op;
      logic [11:0] csr_address;
      logic [31:0] csr_operand;
      logic [31:0] csr_old;
      logic        exception;
      logic [3:0]  cause;
      logic        mret;
      logic        wfi;
   } stim_t;

   typedef struct packed {
      logic        rwe;
      logic [4:0]  rwa;
      logic [31:0] rwd;
      logic        we;
      logic [11:0] wa;
      logic [31:0] wd;
      logic        retired;
      logic        traped;
      logic        mret;
      logic        interupt;
      logic        fetch_trap;
      logic        fetch_mret;
      logic        flush;
      logic        stall;
      logic [31:0] ecp;
      logic [3:0]  cause;
   } obs_t;

   // irq is {eip, sip, tip} held during the commit cycle of the entry
   typedef struct packed {
      obs_t       exp;
      logic [2:0] irq;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [31:0] pc_in;
   logic        rd_write_in;
   logic [4:0]  rd_address_in;
   logic [31:0] rd_data_in;
   logic        csr_write_in;
   logic [1:0]  csr_op_in;
   logic [11:0] csr_address_in;
   logic [31:0] csr_operand_in;
   logic [31:0] csr_old_in;
   logic        exception_in;
   logic [3:0]  exception_cause_in;
   logic        mret_in;
   logic        wfi_in;
   logic        eip, tip, sip;
   logic        reg_write_enable;
   logic [4:0]  reg_write_address;
   logic [31:0] reg_write_data;
   logic        write_enable;
   logic [11:0] write_address;
   logic [31:0] write_data;
   logic        retired, traped, mret;
   logic [31:0] ecp;
   logic [3:0]  trap_cause;
   logic        interupt, fetch_trap, fetch_mret, flush, stall;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   writeback_trap #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
      .rd_write_in(rd_write_in), .rd_address_in(rd_address_in), .rd_data_in(rd_data_in),
      .csr_write_in(csr_write_in), .csr_op_in(csr_op_in), .csr_address_in(csr_address_in),
      .csr_operand_in(csr_operand_in), .csr_old_in(csr_old_in),
      .exception_in(exception_in), .exception_cause_in(exception_cause_in),
      .mret_in(mret_in), .wfi_in(wfi_in), .eip(eip), .tip(tip), .sip(sip),
      .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
      .reg_write_data(reg_write_data), .write_enable(write_enable),
      .write_address(write_address), .write_data(write_data), .retired(retired),
      .traped(traped), .mret(mret), .ecp(ecp), .trap_cause(trap_cause),
      .interupt(interupt), .fetch_trap(fetch_trap), .fetch_mret(fetch_mret),
      .flush(flush), .stall(stall)
   );

   function automatic stim_t bubble();
      stim_t s = '0;
      return s;
   endfunction

   function automatic stim_t alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
      stim_t s = '0;
      s.valid = 1'b1; s.pc = pc; s.rd_write = 1'b1; s.rd_address = rd; s.rd_data = data;
      return s;
   endfunction

   function automatic stim_t csr(input logic [31:0] pc, input logic [1:0] op,
                                 input logic [31:0] operand, input logic [31:0] old);
      stim_t s = alu(pc, 5'd10, old);
      s.csr_write = 1'b1; s.csr_op = op; s.csr_address = 12'h300;
      s.csr_operand = operand; s.csr_old = old;
      return s;
   endfunction

   function automatic obs_t retire_only();
      obs_t o = '0;
      o.retired = 1'b1;
      return o;
   endfunction

   function automatic obs_t gpr_write(input logic [4:0] rd, input logic [31:0] data);
      obs_t o = retire_only();
      o.rwe = 1'b1; o.rwa = rd; o.rwd = data;
      return o;
   endfunction

   function automatic obs_t csr_write(input logic [31:0] old, input logic [31:0] wd);
      obs_t o = gpr_write(5'd10, old);
      o.we = 1'b1; o.wa = 12'h300; o.wd = wd;
      return o;
   endfunction

   function automatic obs_t trap_exp(input logic [31:0] pc, input logic [3:0] cause, input logic intr);
      obs_t o = '0;
      o.traped = 1'b1; o.interupt = intr; o.cause = cause; o.ecp = pc;
      o.fetch_trap = 1'b1; o.flush = 1'b1;
      return o;
   endfunction

   function automatic obs_t stalled();
      obs_t o = '0;
      o.stall = 1'b1;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rwe = reg_write_enable; o.rwa = reg_write_address; o.rwd = reg_write_data;
      o.we = write_enable; o.wa = write_address; o.wd = write_data;
      o.retired = retired; o.traped = traped; o.mret = mret; o.interupt = interupt;
      o.fetch_trap = fetch_trap; o.fetch_mret = fetch_mret; o.flush = flush; o.stall = stall;
      o.ecp = ecp; o.cause = trap_cause;
      return o;
   endfunction

   // Address/data/cause fields only matter while their strobe is expected high
   function automatic obs_t normalize(input obs_t o, input obs_t e);
      obs_t n = o;
      if (!e.rwe) begin n.rwa = '0; n.rwd = '0; end
      if (!e.we) begin n.wa = '0; n.wd = '0; end
      if (!e.traped) begin n.ecp = '0; n.cause = '0; n.interupt = 1'b0; end
      return n;
   endfunction

   task automatic apply(input stim_t s);
      valid_in = s.valid; pc_in = s.pc;
      rd_write_in = s.rd_write; rd_address_in = s.rd_address; rd_data_in = s.rd_data;
      csr_write_in = s.csr_write; csr_op_in = s.csr_op; csr_address_in = s.csr_address;
      csr_operand_in = s.csr_operand; csr_old_in = s.csr_old;
      exception_in = s.exception; exception_cause_in = s.cause;
      mret_in = s.mret; wfi_in = s.wfi;
   endtask

   // Presents one instruction, pushes its expectation, and parks at the sampling edge.
   task automatic drive_cycle(input stim_t s, input obs_t e, input logic [2:0] irq);
      sb_t n;
      @(posedge clk); #1;
      apply(s);
      {eip, sip, tip} = (sb.size() > 0) ? sb[0].irq : 3'b000;
      n.exp = e; n.irq = irq;
      sb.push_back(n);
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t got;
      rst_n = 1'b0;
      apply(bubble());
      {eip, sip, tip} = 3'b000;
      @(posedge clk); @(negedge clk);
      got = sample(); checks++;
      if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_held: got %h required 0", got); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_released: got %h required 0", got); end
      @(posedge clk); @(negedge clk);
      got = sample(); checks++;
      if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_idle: got %h required 0", got); end
   endtask

   task automatic test_commit();
      stim_t st[5]; obs_t ex[5]; sb_t ent; obs_t got;
      st[0] = alu(32'h10, 5'd5, 32'h1234);       ex[0] = gpr_write(5'd5, 32'h1234);
      st[1] = alu(32'h14, 5'd0, 32'hdead);       ex[1] = retire_only();
      st[2] = alu(32'h18, 5'd3, 32'hbeef);       st[2].rd_write = 1'b0; ex[2] = retire_only();
      st[3] = alu(32'h1c, 5'd31, 32'hffff_ffff); ex[3] = gpr_write(5'd31, 32'hffff_ffff);
      st[4] = bubble();                           ex[4] = '0;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(st[i], ex[i], 3'b000);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL commit[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_csr();
      stim_t st[6]; obs_t ex[6]; sb_t ent; obs_t got;
      st[0] = csr(32'h20, 2'd1, 32'h8, 32'h80);        ex[0] = csr_write(32'h80, 32'h88);
      st[1] = csr(32'h24, 2'd2, 32'h8, 32'h80);        ex[1] = csr_write(32'h80, 32'h80);
      st[2] = csr(32'h28, 2'd2, 32'h80, 32'h80);       ex[2] = csr_write(32'h80, 32'h0);
      st[3] = csr(32'h2c, 2'd0, 32'h55, 32'hff);       ex[3] = csr_write(32'hff, 32'h55);
      st[4] = csr(32'h30, 2'd3, 32'ha5a5, 32'hffff);   st[4].rd_write = 1'b0;
      ex[4] = retire_only(); ex[4].we = 1'b1; ex[4].wa = 12'h300; ex[4].wd = 32'ha5a5;
      st[5] = bubble();                                ex[5] = '0;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(st[i], ex[i], 3'b000);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL csr[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_exception();
      stim_t st[4]; obs_t ex[4]; sb_t ent; obs_t got;
      st[0] = csr(32'h100, 2'd0, 32'h1, 32'h0); st[0].exception = 1'b1; st[0].cause = 4'd2;
      ex[0] = trap_exp(32'h100, 4'd2, 1'b0);
      st[1] = alu(32'h104, 5'd6, 32'h5);        ex[1] = '0;
      st[2] = alu(32'h108, 5'd6, 32'h5);        ex[2] = gpr_write(5'd6, 32'h5);
      st[3] = bubble();                         ex[3] = '0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(st[i], ex[i], 3'b000);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL exception[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_interrupt();
      stim_t st[6]; obs_t ex[6]; logic [2:0] iq[6]; sb_t ent; obs_t got;
      st[0] = alu(32'h200, 5'd1, 32'h1); st[0].exception = 1'b1; st[0].cause = 4'd2;
      ex[0] = trap_exp(32'h200, 4'd11, 1'b1); iq[0] = 3'b101;
      st[1] = alu(32'h204, 5'd1, 32'h1); ex[1] = '0; iq[1] = 3'b000;
      st[2] = alu(32'h208, 5'd1, 32'h1); ex[2] = trap_exp(32'h208, 4'd3, 1'b1); iq[2] = 3'b011;
      st[3] = bubble();                  ex[3] = '0; iq[3] = 3'b001;
      st[4] = alu(32'h20c, 5'd1, 32'h1); st[4].mret = 1'b1;
      ex[4] = trap_exp(32'h20c, 4'd7, 1'b1); iq[4] = 3'b001;
      st[5] = bubble();                  ex[5] = '0; iq[5] = 3'b000;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(st[i], ex[i], iq[i]);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL interrupt[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_mret();
      stim_t st[4]; obs_t ex[4]; sb_t ent; obs_t got;
      st[0] = csr(32'h400, 2'd0, 32'h1, 32'h0); st[0].mret = 1'b1;
      ex[0] = retire_only(); ex[0].mret = 1'b1; ex[0].fetch_mret = 1'b1; ex[0].flush = 1'b1;
      st[1] = alu(32'h404, 5'd2, 32'h2); ex[1] = '0;
      st[2] = alu(32'h408, 5'd2, 32'h2); st[2].mret = 1'b1; st[2].exception = 1'b1; st[2].cause = 4'd5;
      ex[2] = trap_exp(32'h408, 4'd5, 1'b0);
      st[3] = bubble(); ex[3] = '0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(st[i], ex[i], 3'b000);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL mret[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_wfi();
      stim_t st[11]; obs_t ex[11]; logic [2:0] iq[11]; sb_t ent; obs_t got;
      st[0] = alu(32'h2f0, 5'd0, 32'h0); st[0].rd_write = 1'b0; st[0].wfi = 1'b1;
      ex[0] = trap_exp(32'h2f0, 4'd3, 1'b1); iq[0] = 3'b010;
      st[1] = alu(32'h2f4, 5'd1, 32'h1); ex[1] = '0; iq[1] = 3'b000;
      st[2] = alu(32'h300, 5'd0, 32'h0); st[2].rd_write = 1'b0; st[2].wfi = 1'b1;
      ex[2] = retire_only(); iq[2] = 3'b000;
      for (int i = 3; i < 8; i++) begin
         st[i] = alu(32'h304, 5'd9, 32'h99); ex[i] = stalled(); iq[i] = 3'b000;
      end
      st[8]  = alu(32'h304, 5'd9, 32'h99); ex[8] = '0; iq[8] = 3'b001;
      st[9]  = alu(32'h308, 5'd9, 32'h77); ex[9] = trap_exp(32'h304, 4'd7, 1'b1); iq[9] = 3'b001;
      st[10] = bubble(); ex[10] = '0; iq[10] = 3'b000;
      for (int i = 0; i < 11; i++) begin
         drive_cycle(st[i], ex[i], iq[i]);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL wfi[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_sleep_bubble();
      stim_t st[6]; obs_t ex[6]; logic [2:0] iq[6]; sb_t ent; obs_t got;
      st[0] = alu(32'h700, 5'd0, 32'h0); st[0].rd_write = 1'b0; st[0].wfi = 1'b1;
      ex[0] = retire_only(); iq[0] = 3'b000;
      st[1] = bubble(); ex[1] = stalled(); iq[1] = 3'b000;
      st[2] = bubble(); ex[2] = stalled(); iq[2] = 3'b001;
      st[3] = alu(32'h704, 5'd4, 32'h4); ex[3] = '0; iq[3] = 3'b001;
      st[4] = alu(32'h708, 5'd4, 32'h8); ex[4] = trap_exp(32'h704, 4'd7, 1'b1); iq[4] = 3'b001;
      st[5] = bubble(); ex[5] = '0; iq[5] = 3'b000;
      for (int i = 0; i < 6; i++) begin
         drive_cycle(st[i], ex[i], iq[i]);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL sleep_bubble[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
   endtask

   task automatic test_reset_sleep();
      stim_t st[4]; obs_t ex[4]; sb_t ent; obs_t got;
      st[0] = alu(32'h600, 5'd0, 32'h0); st[0].rd_write = 1'b0; st[0].wfi = 1'b1; ex[0] = retire_only();
      for (int i = 1; i < 4; i++) begin st[i] = alu(32'h604, 5'd3, 32'h3); ex[i] = stalled(); end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(st[i], ex[i], 3'b000);
         if (sb.size() > 1) begin
            ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
            if (got !== ent.exp) begin errors++; $display("FAIL reset_sleep[%0d]: got %h required %h", i, got, ent.exp); end
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL reset_sleep_pre: got %h required %h", got, ent.exp); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(bubble());
      @(negedge clk);
      got = sample(); checks++;
      if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_sleep_run: got %h required 0", got); end
      drive_cycle(alu(32'h800, 5'd12, 32'hcafe), gpr_write(5'd12, 32'hcafe), 3'b000);
      drive_cycle(bubble(), '0, 3'b000);
      ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL reset_sleep_commit: got %h required %h", got, ent.exp); end
      drive_cycle(bubble(), '0, 3'b000);
      ent = sb.pop_front(); got = normalize(sample(), ent.exp); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL reset_sleep_idle: got %h required %h", got, ent.exp); end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_csr();
      test_exception();
      test_interrupt();
      test_mret();
      test_wfi();
      test_sleep_bubble();
      test_reset_sleep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
